// File: rtl/frame_write_ctrl.sv
// Frame write sequencer for one fabric column: gathers per-row words into FrameData,
// then issues a one-hot FrameStrobe with a setup cycle before it and a hold gap after it.
module frame_write_ctrl #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int StrobeWidth     = 2
) (
    input  logic                                 UserCLK,
    input  logic                                 RST,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [4:0]                           cmd_frame,
    input  logic                                 word_valid,
    output logic                                 word_ready,
    input  logic [FrameBitsPerRow-1:0]           word_data,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int CntW = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        GAP
    } state_t;

    state_t            state;
    logic [4:0]        frame_idx;
    logic [RowW-1:0]   row_cnt;
    logic [CntW-1:0]   strobe_cnt;

    assign cmd_ready  = (state == IDLE);
    assign word_ready = (state == LOAD);
    assign busy       = (state != IDLE);

    // FrameStrobe is a flop with async clear so a reset kills it without waiting for a clock.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            frame_idx   <= '0;
            row_cnt     <= '0;
            strobe_cnt  <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (int'(cmd_frame) >= MaxFramesPerCol) begin
                            err <= 1'b1;
                        end else begin
                            frame_idx <= cmd_frame;
                            row_cnt   <= '0;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        FrameData[int'(row_cnt)*FrameBitsPerRow +: FrameBitsPerRow] <= word_data;
                        if (row_cnt == RowW'(NumRows - 1)) begin
                            state <= SETUP;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                SETUP: begin
                    FrameStrobe <= MaxFramesPerCol'(1) << frame_idx;
                    strobe_cnt  <= CntW'(StrobeWidth - 1);
                    state       <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == '0) begin
                        FrameStrobe <= '0;
                        done        <= 1'b1;
                        state       <= GAP;
                    end else begin
                        strobe_cnt <= strobe_cnt - 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl: normal writes, stalled words, rejected frames,
// back-to-back commands, reset during the strobe and ignored handshakes.
module tb_frame_write_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [4:0]   cmd_frame = '0;
    logic         word_valid = 1'b0;
    logic         word_ready;
    logic [31:0]  word_data = '0;
    logic [127:0] frame_data;
    logic [19:0]  frame_strobe;
    logic         busy;
    logic         done;
    logic         err;

    int errors = 0;
    int checks = 0;

    frame_write_ctrl dut (
        .UserCLK    (clk),
        .RST        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_frame  (cmd_frame),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .FrameData  (frame_data),
        .FrameStrobe(frame_strobe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            word_valid = 1'b1;
            word_data  = w[i];
            tick();
        end
        word_valid = 1'b0;
    endtask

    // Runs from just after the last-word edge until cmd_ready returns (bounded), logging strobe/done.
    task automatic observe(input logic [19:0] exp_sel, output int n_str, output int str_start,
                           output int n_done, output int idle_at, output int bad);
        n_str = 0; str_start = -1; n_done = 0; idle_at = -1; bad = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (frame_strobe == exp_sel) begin
                n_str++;
                if (str_start < 0) str_start = k;
            end else if (frame_strobe != '0) begin
                bad++;
            end
            if (done) n_done++;
            if (cmd_ready) begin
                idle_at = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready got %b exp 0", word_ready); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, err}); end
        checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_framedata got %h exp 0", frame_data); end
        checks++; if (frame_strobe !== '0) begin errors++; $display("FAIL reset_strobe got %h exp 0", frame_strobe); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n_str, s0, n_done, idle_at, bad;
        cmd_valid = 1'b1; cmd_frame = 5'd5;
        tick();
        cmd_valid = 1'b0;
        checks++; if ({word_ready, cmd_ready, busy} !== 3'b101) begin errors++; $display("FAIL basic_load_state got %b exp 101", {word_ready, cmd_ready, busy}); end
        send_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        checks++; if (frame_strobe !== '0) begin errors++; $display("FAIL basic_setup_low got %h exp 0", frame_strobe); end
        checks++; if (frame_data !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_framedata got %h exp 44444444333333332222222211111111", frame_data); end
        observe(20'h00020, n_str, s0, n_done, idle_at, bad);
        checks++; if (n_str !== 2) begin errors++; $display("FAIL basic_strobe_width got %0d exp 2", n_str); end
        checks++; if (s0 !== 1) begin errors++; $display("FAIL basic_strobe_start got %0d exp 1", s0); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_strobe_glitch got %0d exp 0", bad); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", n_done); end
        // accept + 4 words + observe offset: cmd_ready expected 8 cycles after accept
        checks++; if (idle_at + 4 !== 8) begin errors++; $display("FAIL basic_cmd_period got %0d exp 8", idle_at + 4); end
    endtask

    task automatic test_gapped();
        int n_str, s0, n_done, idle_at, bad;
        logic [31:0] w [4];
        w[0] = 32'hA0000001; w[1] = 32'hB0000002; w[2] = 32'hC0000003; w[3] = 32'hD0000004;
        cmd_valid = 1'b1; cmd_frame = 5'd19;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            word_valid = 1'b1; word_data = w[i];
            tick();
            if (i < 3) begin
                word_valid = 1'b0; word_data = 32'hFFFF0000;
                tick();
            end
        end
        // keep offering a word after the last row; it must not be consumed
        word_valid = 1'b1; word_data = 32'hDEADBEEF;
        observe(20'h80000, n_str, s0, n_done, idle_at, bad);
        word_valid = 1'b0;
        checks++; if (frame_data !== {w[3], w[2], w[1], w[0]}) begin errors++; $display("FAIL gapped_framedata got %h exp %h", frame_data, {w[3], w[2], w[1], w[0]}); end
        checks++; if (n_str !== 2 || bad !== 0) begin errors++; $display("FAIL gapped_strobe got n=%0d bad=%0d exp n=2 bad=0", n_str, bad); end
        checks++; if (n_done !== 1 || idle_at !== 4) begin errors++; $display("FAIL gapped_done got done=%0d idle=%0d exp 1/4", n_done, idle_at); end
        tick();
        checks++; if (word_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL gapped_idle got wr=%b busy=%b exp 0/0", word_ready, busy); end
    endtask

    task automatic test_err();
        logic [127:0] held;
        held = frame_data;
        cmd_valid = 1'b1; cmd_frame = 5'd20;
        tick();
        checks++; if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_frame20 got err=%b rdy=%b busy=%b exp 1/1/0", err, cmd_ready, busy); end
        cmd_frame = 5'd31;
        tick();
        checks++; if (err !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL err_frame31 got err=%b rdy=%b exp 1/1", err, cmd_ready); end
        cmd_valid = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_end got %b exp 0", err); end
        checks++; if (frame_strobe !== '0 || frame_data !== held) begin errors++; $display("FAIL err_no_effect got strobe=%h data=%h exp 0 / %h", frame_strobe, frame_data, held); end
    endtask

    task automatic test_back_to_back();
        int n_str, s0, n_done, idle_at, bad;
        cmd_valid = 1'b1; cmd_frame = 5'd0;
        tick();
        cmd_frame = 5'd1;
        send_words(32'h00000010, 32'h00000020, 32'h00000030, 32'h00000040);
        observe(20'h00001, n_str, s0, n_done, idle_at, bad);
        checks++; if (n_str !== 2 || bad !== 0 || n_done !== 1 || idle_at !== 4) begin errors++; $display("FAIL b2b_first got n=%0d bad=%0d done=%0d idle=%0d exp 2/0/1/4", n_str, bad, n_done, idle_at); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got wr=%b exp 1", word_ready); end
        send_words(32'h00000050, 32'h00000060, 32'h00000070, 32'h00000080);
        observe(20'h00002, n_str, s0, n_done, idle_at, bad);
        checks++; if (n_str !== 2 || bad !== 0 || n_done !== 1) begin errors++; $display("FAIL b2b_second got n=%0d bad=%0d done=%0d exp 2/0/1", n_str, bad, n_done); end
        checks++; if (frame_data !== 128'h00000080_00000070_00000060_00000050) begin errors++; $display("FAIL b2b_framedata got %h exp 00000080000000700000006000000050", frame_data); end
    endtask

    task automatic test_reset_mid();
        int n_str, s0, n_done, idle_at, bad;
        int saw_done;
        cmd_valid = 1'b1; cmd_frame = 5'd3;
        tick();
        cmd_valid = 1'b0;
        send_words(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
        tick();
        checks++; if (frame_strobe !== 20'h00008) begin errors++; $display("FAIL rstmid_strobe_on got %h exp 00008", frame_strobe); end
        rst = 1'b1;
        #1;
        checks++; if (frame_strobe !== '0) begin errors++; $display("FAIL rstmid_strobe_async got %h exp 0", frame_strobe); end
        checks++; if (frame_data !== '0) begin errors++; $display("FAIL rstmid_framedata got %h exp 0", frame_data); end
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done++;
        end
        checks++; if (saw_done !== 0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_no_done got done=%0d rdy=%b exp 0/1", saw_done, cmd_ready); end
        cmd_valid = 1'b1; cmd_frame = 5'd7;
        tick();
        cmd_valid = 1'b0;
        send_words(32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);
        observe(20'h00080, n_str, s0, n_done, idle_at, bad);
        checks++; if (n_str !== 2 || s0 !== 1 || bad !== 0 || n_done !== 1 || idle_at !== 4) begin errors++; $display("FAIL rstmid_fresh got n=%0d s=%0d bad=%0d done=%0d idle=%0d exp 2/1/0/1/4", n_str, s0, bad, n_done, idle_at); end
        checks++; if (frame_data !== 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000) begin errors++; $display("FAIL rstmid_fresh_data got %h exp CAFE0003CAFE0002CAFE0001CAFE0000", frame_data); end
    endtask

    task automatic test_ignored();
        int n_str, s0, n_done, idle_at, bad;
        logic [127:0] held;
        held = frame_data;
        word_valid = 1'b1; word_data = 32'h5A5A5A5A;
        tick();
        tick();
        checks++; if (word_ready !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_word_idle got wr=%b rdy=%b busy=%b exp 0/1/0", word_ready, cmd_ready, busy); end
        checks++; if (frame_data !== held) begin errors++; $display("FAIL ign_word_data got %h exp %h", frame_data, held); end
        word_valid = 1'b0;
        cmd_valid = 1'b1; cmd_frame = 5'd2;
        tick();
        cmd_frame = 5'd9;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b0 || word_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ign_cmd_load got rdy=%b wr=%b err=%b exp 0/1/0", cmd_ready, word_ready, err); end
        cmd_valid = 1'b0;
        send_words(32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D);
        observe(20'h00004, n_str, s0, n_done, idle_at, bad);
        checks++; if (n_str !== 2 || bad !== 0 || n_done !== 1) begin errors++; $display("FAIL ign_cmd_frame got n=%0d bad=%0d done=%0d exp 2/0/1", n_str, bad, n_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_err();
        test_back_to_back();
        test_reset_mid();
        test_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
